// File: rtl/axis_elastic_fifo_if.sv
// AXI4-Stream handshake bundle (tvalid/tready/tdata/tlast) used on both sides of the elastic FIFO.
interface axis_elastic_fifo_if #(
   parameter int unsigned DataWidth = 32
);
   logic                 tvalid;
   logic                 tready;
   logic [DataWidth-1:0] tdata;
   logic                 tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_elastic_fifo.sv
// AXI4-Stream elastic buffer: circular store of {tlast,tdata} with registered handshake
// flags, fill level and almost-full status. No combinational path from o_tready to i_tready.
module axis_elastic_fifo #(
   parameter int unsigned DataWidth       = 32,
   parameter int unsigned Depth           = 4,
   parameter int unsigned AlmostFullLevel = Depth - 1
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   axis_elastic_fifo_if.slave       i_axis,
   axis_elastic_fifo_if.master      o_axis,
   output logic [$clog2(Depth):0]   level,
   output logic                     almost_full
);

   localparam int unsigned PtrWidth = $clog2(Depth);
   localparam int unsigned CntWidth = PtrWidth + 1;

   typedef struct packed {
      logic                 tlast;
      logic [DataWidth-1:0] tdata;
   } entry_t;

   entry_t              mem [Depth];
   logic [PtrWidth-1:0] wr_ptr;
   logic [PtrWidth-1:0] rd_ptr;
   logic [CntWidth-1:0] count;
   logic [CntWidth-1:0] count_next;
   logic                tvalid_q;
   logic                tready_q;
   logic                push_c;
   logic                pop_c;

   assign push_c = i_axis.tvalid & tready_q;
   assign pop_c  = tvalid_q & o_axis.tready;

   // Occupancy after this edge; drives every registered flag.
   always_comb begin
      count_next = count;
      case ({push_c, pop_c})
         2'b10:   count_next = count + CntWidth'(1);
         2'b01:   count_next = count - CntWidth'(1);
         default: count_next = count;
      endcase
   end

   // Pointers and flags; storage contents are deliberately left out of reset.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         tvalid_q    <= 1'b0;
         tready_q    <= 1'b0;
         almost_full <= 1'b0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PtrWidth'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PtrWidth'(1);
         count       <= count_next;
         tvalid_q    <= (count_next != '0);
         tready_q    <= (count_next != CntWidth'(Depth));
         almost_full <= (count_next >= CntWidth'(AlmostFullLevel));
      end
   end

   always_ff @(posedge aclk) begin
      if (push_c) mem[wr_ptr] <= '{tlast: i_axis.tlast, tdata: i_axis.tdata};
   end

   assign i_axis.tready = tready_q;
   assign o_axis.tvalid = tvalid_q;
   assign o_axis.tdata  = mem[rd_ptr].tdata;
   assign o_axis.tlast  = mem[rd_ptr].tlast;
   assign level         = count;

endmodule

// File: tb/tb_axis_elastic_fifo.sv
// Scoreboard bench for axis_elastic_fifo (Depth=4): directed fill/drain/stream/reset plus random packets.
module tb_axis_elastic_fifo;

   localparam int unsigned DataWidth = 32;
   localparam int unsigned Depth     = 4;

   logic       clk = 1'b0;
   logic       aresetn;
   logic [2:0] level;
   logic       almost_full;

   axis_elastic_fifo_if #(.DataWidth(DataWidth)) in_if ();
   axis_elastic_fifo_if #(.DataWidth(DataWidth)) out_if ();

   axis_elastic_fifo #(.DataWidth(DataWidth), .Depth(Depth), .AlmostFullLevel(3)) dut (
      .aclk        (clk),
      .aresetn     (aresetn),
      .i_axis      (in_if.slave),
      .o_axis      (out_if.master),
      .level       (level),
      .almost_full (almost_full)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_pops   = 0;
   logic [32:0] exp_q [$];
   logic        rand_rdy = 1'b0;
   logic        hold_v   = 1'b0;
   logic [32:0] hold_w;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: handshakes are sampled mid-cycle, ahead of the edge that completes them.
   always @(negedge clk) begin
      logic [32:0] e;
      if (!aresetn) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v)
            chk("stall_stable", 64'({out_if.tvalid, out_if.tlast, out_if.tdata}), 64'({1'b1, hold_w}));
         if (out_if.tvalid && out_if.tready) begin
            if (exp_q.size() == 0) fail_now("unexpected_word");
            else begin
               e = exp_q.pop_front();
               chk("sb_word", 64'({out_if.tlast, out_if.tdata}), 64'(e));
               n_pops++;
            end
         end
         hold_v = out_if.tvalid && !out_if.tready;
         hold_w = {out_if.tlast, out_if.tdata};
         if (in_if.tvalid && in_if.tready) exp_q.push_back({in_if.tlast, in_if.tdata});
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         out_if.tready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int          base;
      int unsigned len;
      int          cyc;
      logic        acc;

      // 1: reset with traffic present
      aresetn       = 1'b0;
      in_if.tvalid  = 1'b1;
      in_if.tdata   = 32'hDEAD_BEEF;
      in_if.tlast   = 1'b0;
      out_if.tready = 1'b1;
      #2;
      chk("rst_o_tvalid", 64'(out_if.tvalid), 64'd0);
      chk("rst_i_tready", 64'(in_if.tready), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      repeat (2) tick();
      aresetn = 1'b1;
      #1;
      chk("rel_i_tready_pre", 64'(in_if.tready), 64'd0);
      tick();
      chk("rel_i_tready", 64'(in_if.tready), 64'd1);
      chk("rel_o_tvalid", 64'(out_if.tvalid), 64'd0);
      chk("rel_level", 64'(level), 64'd0);
      in_if.tvalid  = 1'b0;
      out_if.tready = 1'b0;
      tick();

      // 2: fill with downstream stalled
      in_if.tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_if.tdata = 32'hA0 + 32'(i);
         tick();
         chk("fill_level", 64'(level), 64'(i + 1));
         chk("fill_afull", 64'(almost_full), (i >= 2) ? 64'd1 : 64'd0);
         chk("fill_i_tready", 64'(in_if.tready), (i == 3) ? 64'd0 : 64'd1);
      end
      in_if.tdata = 32'hA4;
      tick();
      chk("full_level", 64'(level), 64'd4);
      chk("full_i_tready", 64'(in_if.tready), 64'd0);
      chk("full_head", 64'(out_if.tdata), 64'hA0);

      // 3: drain; A4 enters once space opens
      base          = n_pops;
      out_if.tready = 1'b1;
      tick();
      chk("drain1_level", 64'(level), 64'd3);
      chk("drain1_i_tready", 64'(in_if.tready), 64'd1);
      tick();
      chk("drain2_level", 64'(level), 64'd3);
      in_if.tvalid = 1'b0;
      repeat (3) tick();
      chk("drain_level0", 64'(level), 64'd0);
      chk("drain_o_tvalid", 64'(out_if.tvalid), 64'd0);
      chk("drain_afull", 64'(almost_full), 64'd0);
      chk("drain_pops", 64'(n_pops - base), 64'd5);

      // 4: streaming at one word per cycle
      base         = n_pops;
      in_if.tvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_if.tdata = 32'(i);
         in_if.tlast = (i % 10 == 9);
         tick();
         chk("stream_level", 64'(level), 64'd1);
         if (i == 0) chk("stream_first_valid", 64'(out_if.tvalid), 64'd1);
      end
      in_if.tvalid = 1'b0;
      tick();
      chk("stream_pops", 64'(n_pops - base), 64'd100);
      chk("stream_empty", 64'(level), 64'd0);

      // 5: random packets with random backpressure
      rand_rdy = 1'b1;
      for (int p = 0; p < 16; p++) begin
         len = $urandom_range(1, 7);
         for (int w = 0; w < int'(len); w++) begin
            in_if.tvalid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            in_if.tvalid = 1'b1;
            in_if.tdata  = $urandom;
            in_if.tlast  = (w == int'(len) - 1);
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 100) begin
               acc = in_if.tready;
               tick();
               cyc++;
            end
            if (!acc) fail_now("rand_accept_timeout");
         end
      end
      in_if.tvalid = 1'b0;
      rand_rdy     = 1'b0;
      tick();
      out_if.tready = 1'b1;
      cyc = 0;
      while ((exp_q.size() != 0 || out_if.tvalid) && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("rand_sb_empty", 64'(exp_q.size()), 64'd0);
      chk("rand_level0", 64'(level), 64'd0);

      // 6: asynchronous reset at level 3
      out_if.tready = 1'b0;
      in_if.tvalid  = 1'b1;
      in_if.tlast   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_if.tdata = 32'h11 * 32'(i + 1);
         tick();
      end
      in_if.tvalid = 1'b0;
      chk("pre_rst_level", 64'(level), 64'd3);
      #2;
      aresetn = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_level", 64'(level), 64'd0);
      chk("mid_rst_o_tvalid", 64'(out_if.tvalid), 64'd0);
      chk("mid_rst_afull", 64'(almost_full), 64'd0);
      tick();
      aresetn = 1'b1;
      tick();
      chk("post_rst_i_tready", 64'(in_if.tready), 64'd1);
      in_if.tvalid = 1'b1;
      in_if.tdata  = 32'h55;
      in_if.tlast  = 1'b1;
      tick();
      in_if.tvalid = 1'b0;
      chk("post_rst_head", 64'(out_if.tdata), 64'h55);
      chk("post_rst_level", 64'(level), 64'd1);
      base          = n_pops;
      out_if.tready = 1'b1;
      repeat (3) tick();
      chk("post_rst_pops", 64'(n_pops - base), 64'd1);
      chk("post_rst_sb_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
